// File: rtl/shift_seq_ctrl.sv
// Multi-cycle SLL/SRL/SRA unit that reuses a fixed shift-by-2 step, plus a shift-by-1
// step for an odd remainder. Sequenced with a start/ready/busy/done handshake.
module shift_seq_ctrl #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [1:0]         op,
    input  logic [WIDTH-1:0]   A,
    input  logic [SHAMT_W-1:0] shamt,
    output logic               ready,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   B
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        OP_SLL  = 2'b00,
        OP_SRL  = 2'b01,
        OP_SRA  = 2'b10,
        OP_PASS = 2'b11
    } op_t;

    state_t             state_q, state_d;
    op_t                op_q, op_d;
    logic [WIDTH-1:0]   data_q, data_d;
    logic [SHAMT_W-1:0] rem_q, rem_d;
    logic [WIDTH-1:0]   b_q, b_d;

    logic               step2;
    logic [WIDTH-1:0]   shifted;
    logic [SHAMT_W-1:0] rem_next;

    // One step of the datapath: by 2 while at least two positions remain, else by 1.
    // SRA keeps the MSB, so the original sign bit is replicated on every step.
    always_comb begin
        step2    = (rem_q >= SHAMT_W'(2));
        shifted  = data_q;
        rem_next = step2 ? (rem_q - SHAMT_W'(2)) : '0;
        case (op_q)
            OP_SLL:  shifted = step2 ? {data_q[WIDTH-3:0], 2'b00}
                                     : {data_q[WIDTH-2:0], 1'b0};
            OP_SRL:  shifted = step2 ? {2'b00, data_q[WIDTH-1:2]}
                                     : {1'b0, data_q[WIDTH-1:1]};
            OP_SRA:  shifted = step2 ? {{2{data_q[WIDTH-1]}}, data_q[WIDTH-1:2]}
                                     : {data_q[WIDTH-1], data_q[WIDTH-1:1]};
            default: shifted = data_q;
        endcase
    end

    // NOTE: every signal gets a default first so no path can leave it unassigned,
    // which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        data_d  = data_q;
        rem_d   = rem_q;
        b_d     = b_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    data_d = A;
                    rem_d  = shamt;
                    op_d   = op_t'(op);
                    if (op_t'(op) == OP_PASS || shamt == '0) begin
                        b_d     = A;
                        state_d = DONE;
                    end else begin
                        state_d = SHIFT;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                data_d = shifted;
                rem_d  = rem_next;
                if (rem_next == '0) begin
                    b_d     = shifted;
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update
    // together from values sampled before the edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            op_q    <= OP_SLL;
            data_q  <= '0;
            rem_q   <= '0;
            b_q     <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            data_q  <= data_d;
            rem_q   <= rem_d;
            b_q     <= b_d;
        end
    end

    assign ready = (state_q == IDLE) || (state_q == DONE);
    assign busy  = (state_q == SHIFT);
    assign done  = (state_q == DONE);
    assign B     = b_q;

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Randomized scoreboard bench for shift_seq_ctrl: the driver predicts results and
// completion cycles from shift arithmetic; a monitor checks handshake and B every cycle.
module tb_shift_seq_ctrl;

    localparam int WIDTH   = 32;
    localparam int SHAMT_W = 5;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic [1:0]       op_i;
    logic [WIDTH-1:0] a_i;
    logic [4:0]       shamt_i;
    logic             ready_o, busy_o, done_o;
    logic [WIDTH-1:0] b_o;

    shift_seq_ctrl #(.WIDTH(WIDTH), .SHAMT_W(SHAMT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .op    (op_i),
        .A     (a_i),
        .shamt (shamt_i),
        .ready (ready_o),
        .busy  (busy_o),
        .done  (done_o),
        .B     (b_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int               due;
        logic [WIDTH-1:0] b;
    } exp_t;

    exp_t             exp_q[$];
    int               cyc       = 0;
    int               due_last  = 0;
    logic [WIDTH-1:0] model_b   = '0;
    bit               mon_en    = 1'b0;
    int               n_checks  = 0;
    int               n_pass    = 0;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
    endtask

    function automatic logic [WIDTH-1:0] ref_result(input logic [1:0] o,
                                                     input logic [WIDTH-1:0] a, input int sh);
        logic signed [WIDTH-1:0] s;
        s = a;
        case (o)
            2'b00:   return a << sh;
            2'b01:   return a >> sh;
            2'b10:   return s >>> sh;
            default: return a;
        endcase
    endfunction

    function automatic int ref_latency(input logic [1:0] o, input int sh);
        if (o == 2'b11 || sh == 0) return 1;
        return 1 + (sh + 1) / 2;
    endfunction

    // One negedge of stimulus; the unit is modelled as ready once the last
    // accepted operation has reached its completion cycle.
    task automatic drive(input bit st, input logic [1:0] o, input logic [WIDTH-1:0] a,
                         input int sh);
        exp_t e;
        @(negedge clk);
        start   = st;
        op_i    = o;
        a_i     = a;
        shamt_i = sh[4:0];
        if (rst_n && st && cyc >= due_last) begin
            e.due    = cyc + ref_latency(o, sh);
            e.b      = ref_result(o, a, sh);
            due_last = e.due;
            exp_q.push_back(e);
        end
    endtask

    task automatic idle();
        drive(1'b0, 2'($urandom_range(0, 3)), $urandom, int'($urandom_range(0, 31)));
    endtask

    task automatic wait_ready();
        while (cyc + 1 < due_last) idle();
    endtask

    task automatic issue(input logic [1:0] o, input logic [WIDTH-1:0] a, input int sh);
        wait_ready();
        drive(1'b1, o, a, sh);
    endtask

    task automatic stray_start();
        drive(1'b1, 2'($urandom_range(0, 3)), $urandom, int'($urandom_range(0, 31)));
    endtask

    task automatic abort();
        @(negedge clk);
        rst_n   = 1'b0;
        start   = 1'b1;
        a_i     = $urandom;
        shamt_i = 5'd9;
        exp_q.delete();
        due_last = 0;
        model_b  = '0;
        @(negedge clk);
        rst_n = 1'b1;
        start = 1'b0;
    endtask

    // Monitor: handshake levels every cycle, results popped whenever done shows.
    initial forever begin
        exp_t e;
        bit   rdy_m;
        @(posedge clk);
        #1;
        if (mon_en) begin
            rdy_m = (cyc >= due_last);
            check("ready", 64'(ready_o), 64'(rdy_m));
            check("busy", 64'(busy_o), 64'(!rdy_m));
            if (done_o) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL spurious_done @cyc %0d: got done=1 expected done=0", cyc);
                end else begin
                    e = exp_q.pop_front();
                    check("done_cycle", 64'(cyc), 64'(e.due));
                    check("result_B", 64'(b_o), 64'(e.b));
                    model_b = e.b;
                end
            end else begin
                check("B_hold", 64'(b_o), 64'(model_b));
                if (exp_q.size() != 0 && cyc > exp_q[0].due) begin
                    e = exp_q.pop_front();
                    n_checks++;
                    $display("FAIL done_timeout @cyc %0d: got no done expected done at cyc %0d",
                             cyc, e.due);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int gap, r, sh;
        rst_n   = 1'b0;
        start   = 1'b1;
        op_i    = 2'b00;
        a_i     = 32'hA5A5_A5A5;
        shamt_i = 5'd3;
        repeat (2) @(posedge clk);
        mon_en = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        start = 1'b0;
        idle();

        // Directed cases from the bring-up list.
        issue(2'b00, 32'hFFFF_FFFF, 2);  idle();
        issue(2'b10, 32'h8000_0000, 5);  idle();
        issue(2'b01, 32'hFFFF_FFFF, 31); idle();
        issue(2'b00, 32'h1234_5678, 0);  idle();
        issue(2'b11, 32'hDEAD_BEEF, 7);  idle();

        // Start while busy is ignored; the first result must be unaffected.
        issue(2'b10, 32'h9ABC_DEF0, 13);
        idle();
        stray_start();
        stray_start();

        // Reset mid-shift with start held: no done, B cleared.
        issue(2'b01, 32'hCAFE_F00D, 20);
        repeat (3) idle();
        abort();
        repeat (3) idle();

        // Back-to-back, including consecutive one-cycle completions.
        issue(2'b00, 32'h0000_00FF, 3);
        issue(2'b10, 32'hF000_000F, 4);
        issue(2'b11, 32'h1111_2222, 9);
        issue(2'b01, 32'h3333_4444, 0);
        issue(2'b10, 32'h7FFF_FFFF, 1);
        idle();

        for (int i = 0; i < 150; i++) begin
            gap = int'($urandom_range(0, 2));
            repeat (gap) idle();
            r  = int'($urandom_range(0, 19));
            sh = (r < 3) ? 31 : (r < 5) ? 0 : int'($urandom_range(0, 31));
            issue(2'($urandom_range(0, 3)), $urandom, sh);
            if (r == 7 && cyc + 3 < due_last) begin
                idle();
                stray_start();
            end else if (r == 8 && cyc + 3 < due_last) begin
                idle();
                abort();
            end
        end

        for (int k = 0; k < 40 && exp_q.size() != 0; k++) idle();
        repeat (3) idle();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/shift_seq_ctrl.md
Name: shift_seq_ctrl

Overview:
- Multi-cycle shift controller for the single-cycle CPU datapath.
- Performs SLL/SRL/SRA by variable amount by repeatedly applying a fixed shift-by-2 step (same step as the branch-offset shifter), with a shift-by-1 step for an odd remainder.
- Sits beside the ALU, sequenced by a start/busy/done handshake.
- Trades latency for area versus a full barrel shifter.

Parameters:
- WIDTH, 32, data width of operand and result.
- SHAMT_W, 5, width of shift-amount input; must satisfy 2**SHAMT_W <= WIDTH.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- start  input  1  request pulse; sampled only when the unit is ready
- op  input  2  00 SLL, 01 SRL, 10 SRA, 11 pass-through
- A  input  WIDTH  operand
- shamt  input  SHAMT_W  shift amount
- ready  output  1  unit accepts start this cycle
- busy  output  1  shift in progress
- done  output  1  one-cycle pulse: B valid and new
- B  output  WIDTH  result register

Behaviour:
Reset and clocking:
- One clock. Reset is synchronous and active-low, sampled on rising clk edge.
- Reset values: state IDLE, B=0, done=0, busy=0, ready=1, internal data/remaining/op regs = 0.

States and outputs:
- States: IDLE, SHIFT, DONE.
- ready = (state==IDLE) || (state==DONE).
- busy = (state==SHIFT).
- done = (state==DONE).

Transitions:
- IDLE/DONE with start=1: latch A into data reg, shamt into rem, op into op reg.
  - op==11 or shamt==0 -> DONE (B <= A at that edge).
  - Otherwise -> SHIFT.
- IDLE/DONE with start=0: go to / stay in IDLE. B holds its value.
- SHIFT, each edge:
  - rem>=2: shift data by 2, rem -= 2.
  - rem==1: shift data by 1, rem = 0.
  - If the new rem==0: B <= shifted data, go to DONE. Else stay in SHIFT.

Shift rules:
- SLL fills zeros at the LSBs.
- SRL fills zeros at the MSBs.
- SRA replicates the original sign bit A[WIDTH-1] into the vacated MSBs on every step.

Latency and throughput:
- done is high in cycle c0+N, where c0 is the cycle start is sampled.
- N = 1 + ceil(shamt/2); N = 1 when shamt==0 or op==11.
- Max N = 17 for shamt=31.
- start during DONE is accepted, giving back-to-back operations with no idle bubble.

Boundary conditions:
- start while busy: ignored entirely; latched operands unchanged; no queueing.
- Inputs A/op/shamt changing during SHIFT: no effect (operands latched).
- B changes only on the completion edge; stable between done pulses.
- Reset asserted mid-SHIFT: next edge forces IDLE and B=0; no done pulse for the aborted operation.
- Reset and start in the same cycle: reset wins.
- done is never high for two consecutive cycles unless a new start was accepted in the DONE cycle and that operation also completes in one cycle (shamt==0 or op==11).

Test Plan:
- Reset: rst_n=0 for 2 cycles with start=1 -> B=0, done=0, busy=0, ready=1.
- SLL: A=32'hFFFFFFFF, shamt=2, op=00 -> done in c0+2, B=32'hFFFFFFFC; busy high exactly 1 cycle.
- SRA odd amount: A=32'h80000000, shamt=5, op=10 -> done in c0+4, B=32'hFC000000.
- SRL max: A=32'hFFFFFFFF, shamt=31, op=01 -> done in c0+17, B=32'h00000001.
- Zero/pass-through: shamt=0 with A=32'h12345678, then op=11 with shamt=7 and A=32'hDEADBEEF -> each done in c0+1; B=32'h12345678 then 32'hDEADBEEF.
- Ignored start and abort:
  - Second start mid-SHIFT -> ignored; the first result completes correctly.
  - Issuing rst_n=0 mid-SHIFT -> IDLE, B=0, no done pulse.
  - Back-to-back start in the DONE cycle -> the second result follows with no gap.
